// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic [31:0] ERR_DATA             = 32'hDEADBEEF;
    localparam int          MAX_WAIT_DEFAULT     = 15;
    localparam int          STARVE_LIMIT_DEFAULT = 2;

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Wait counter for one memory access: cleared on grant, advanced on each unanswered
// busy cycle, and saturating at MAX_WAIT where it reports expiry.
module arb_wait_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic cnt_en,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (cnt_en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch stage and the MEM stage: data has priority,
// a waiting fetch wins after STARVE_LIMIT back-to-back data grants, stuck accesses time out.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT     = MAX_WAIT_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        Stall,
    output logic        mem_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e    state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          grant_if, grant_dm;
    logic          busy, finish, timeout, expired;
    logic [31:0]   resp_data;

    arb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (grant_if | grant_dm),
        .cnt_en  (busy & ~mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        case (state)
            IDLE: begin
                if (if_req && (!dm_req || starve_cnt >= SW'(STARVE_LIMIT))) begin
                    grant_if  = 1'b1;
                    state_nxt = IBUSY;
                end else if (dm_req) begin
                    grant_dm  = 1'b1;
                    state_nxt = DBUSY;
                end
            end
            IBUSY, DBUSY: begin
                if (mem_ready || expired) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A ready response on the expiry cycle still counts as a normal completion.
    assign busy      = (state == IBUSY) || (state == DBUSY);
    assign finish    = busy && (mem_ready || expired);
    assign timeout   = busy && !mem_ready && expired;
    assign resp_data = timeout ? ERR_DATA : mem_rdata;
    assign Stall     = (if_req & ~if_ack) | (dm_req & ~dm_ack);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_err    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state  <= state_nxt;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            if (grant_if || grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= grant_dm & dm_we;
                mem_addr  <= grant_dm ? dm_addr : if_addr;
                mem_wdata <= grant_dm ? dm_wdata : '0;
            end
            if (grant_dm && starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end else if (grant_if) begin
                starve_cnt <= '0;
            end
            if (finish) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (state == IBUSY) begin
                    if_ack   <= 1'b1;
                    if_rdata <= resp_data;
                end else begin
                    dm_ack <= 1'b1;
                    if (!mem_we) begin
                        dm_rdata <= resp_data;
                    end
                end
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: single-access vector table, hand-written arbitration and reset
// sequences, and a randomized run against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int MW = 15;
    localparam int SL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, if_ack, dm_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, if_rdata, dm_rdata;
    logic        mem_req, mem_we, mem_ready, Stall, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total      = 0;
    int bad        = 0;
    int resp_delay = 0;
    int busy_cnt   = 0;
    int edge_no    = 0;
    bit noise_en   = 1'b0;

    typedef struct {
        bit          data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        int          exp_lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_WAIT     (MW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .Stall     (Stall),
        .mem_err   (mem_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h20080005;
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: answers resp_delay cycles after mem_req rises (never if negative).
    task automatic tick();
        @(posedge clk);
        #1;
        edge_no++;
        if (mem_req) begin
            mem_ready = (busy_cnt == resp_delay);
            mem_rdata = mem_ready ? mem_word(mem_addr) : $urandom;
            busy_cnt++;
        end else begin
            mem_ready = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
            busy_cnt  = 0;
        end
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        if_req   = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        if_addr  = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat = -1;
        if (v.data) begin
            dm_req   = 1'b1;
            dm_we    = v.we;
            dm_addr  = v.addr;
            dm_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        resp_delay = v.delay;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            tick();
            check1($sformatf("v%0d_excl_ack", idx), if_ack & dm_ack, 1'b0);
            if ((v.data ? dm_ack : if_ack) == 1'b1) begin
                lat = c;
            end else begin
                check1($sformatf("v%0d_stall", idx), Stall, 1'b1);
                if (mem_req) begin
                    check32($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
                    check1($sformatf("v%0d_mem_we", idx), mem_we, v.we);
                    if (v.we) check32($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
                end
            end
        end
        check32($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check1($sformatf("v%0d_stall_at_ack", idx), Stall, 1'b0);
        check1($sformatf("v%0d_mem_req_at_ack", idx), mem_req, 1'b0);
        check32($sformatf("v%0d_rdata", idx), v.data ? dm_rdata : if_rdata, v.exp_rdata);
        check1($sformatf("v%0d_mem_err", idx), mem_err, v.exp_err);
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        check1($sformatf("v%0d_ack_one_cycle", idx), v.data ? dm_ack : if_ack, 1'b0);
    endtask

    task automatic run_random(input int n_cycles);
        int          owner = 0;
        int          ack_owner;
        int          ack_edge = 0;
        int          free_edge;
        int          e;
        bit          to = 1'b0;
        bit          cur_we = 1'b0;
        bit          exp_err = 1'b0;
        bit          starved;
        logic [31:0] cur_addr = '0;
        logic [31:0] cur_wdata = '0;
        logic [31:0] exp_if_rd = '0;
        logic [31:0] exp_dm_rd = '0;
        bit          hist[$];
        apply_reset();
        noise_en  = 1'b1;
        free_edge = edge_no + 1;
        for (int n = 0; n < n_cycles; n++) begin
            // Predict what the coming edge does from the requests now on the inputs.
            e         = edge_no + 1;
            ack_owner = 0;
            if (owner != 0 && e == ack_edge) begin
                ack_owner = owner;
                if (owner == 1) exp_if_rd = to ? 32'hDEADBEEF : mem_word(cur_addr);
                else if (!cur_we) exp_dm_rd = to ? 32'hDEADBEEF : mem_word(cur_addr);
                if (to) exp_err = 1'b1;
                free_edge = e + 2;
                owner     = 0;
            end else if (owner == 0 && e >= free_edge && (if_req || dm_req)) begin
                starved = (hist.size() >= SL);
                foreach (hist[i]) if (!hist[i]) starved = 1'b0;
                owner = (dm_req && !(if_req && starved)) ? 2 : 1;
                hist.push_back(owner == 2);
                if (hist.size() > SL) void'(hist.pop_front());
                cur_we    = (owner == 2) && dm_we;
                cur_addr  = (owner == 2) ? dm_addr : if_addr;
                cur_wdata = dm_wdata;
                if (cur_we) begin
                    resp_delay = int'($urandom_range(0, 4));
                end else begin
                    case ($urandom_range(0, 9))
                        0:       resp_delay = -1;
                        1:       resp_delay = MW;
                        default: resp_delay = int'($urandom_range(0, 4));
                    endcase
                end
                to       = (resp_delay < 0) || (resp_delay > MW);
                ack_edge = e + (to ? MW : resp_delay) + 1;
            end
            tick();
            check1("rnd_excl_ack", if_ack & dm_ack, 1'b0);
            check1("rnd_if_ack", if_ack, ack_owner == 1);
            check1("rnd_dm_ack", dm_ack, ack_owner == 2);
            check1("rnd_mem_req", mem_req, owner != 0);
            if (owner != 0) begin
                check32("rnd_mem_addr", mem_addr, cur_addr);
                check1("rnd_mem_we", mem_we, cur_we);
                if (cur_we) check32("rnd_mem_wdata", mem_wdata, cur_wdata);
            end
            check32("rnd_if_rdata", if_rdata, exp_if_rd);
            check32("rnd_dm_rdata", dm_rdata, exp_dm_rd);
            check1("rnd_mem_err", mem_err, exp_err);
            if (if_ack) begin
                if_req = 1'b0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 32'($urandom_range(0, 1023)) << 2;
            end
            if (dm_ack) begin
                dm_req = 1'b0;
                dm_we  = 1'b0;
            end else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req   = 1'b1;
                dm_we    = ($urandom_range(0, 3) == 0);
                dm_addr  = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
                dm_wdata = $urandom;
            end
            #1;
            check1("rnd_stall", Stall, (if_req && ack_owner != 1) || (dm_req && ack_owner != 2));
        end
        noise_en = 1'b0;
        if_req   = 1'b0;
        dm_req   = 1'b0;
    endtask

    initial begin
        logic [31:0] grants[4];
        int          n_grants;
        logic        prev_req;
        int          dm_acks;

        reset     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        vecs[0] = '{1'b0, 1'b0, 32'h40,   32'h0,        2, 4,  32'h20080005,       1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h1000, 32'h0,        0, 2,  mem_word(32'h1000), 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h1004, 32'hCAFEF00D, 1, 3,  mem_word(32'h1000), 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h2000, 32'h0,        14, 16, mem_word(32'h2000), 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h2004, 32'h0,        15, 17, mem_word(32'h2004), 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h80,   32'h0,        -1, 17, 32'hDEADBEEF,       1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h3000, 32'h0,        3, 5,  mem_word(32'h3000), 1'b1};

        apply_reset();
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        check1("rst_if_ack", if_ack, 1'b0);
        check1("rst_dm_ack", dm_ack, 1'b0);
        check32("rst_if_rdata", if_rdata, 32'h0);
        check32("rst_dm_rdata", dm_rdata, 32'h0);
        check1("rst_mem_err", mem_err, 1'b0);
        check1("rst_stall", Stall, 1'b0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
        tick();
        tick();
        check1("err_sticky_idle", mem_err, 1'b1);
        apply_reset();
        check1("err_cleared_by_reset", mem_err, 1'b0);

        // Fetch and load together: the load goes first, fetch follows after RESP and IDLE.
        apply_reset();
        resp_delay = 1;
        if_req  = 1'b1;
        if_addr = 32'h40;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h1000;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check1($sformatf("both_c%0d_stall", c), Stall, c < 7);
            check1($sformatf("both_c%0d_if_ack", c), if_ack, c == 7);
            check1($sformatf("both_c%0d_dm_ack", c), dm_ack, c == 3);
            case (c)
                1: check32("both_first_addr", mem_addr, 32'h1000);
                3: check32("both_dm_rdata", dm_rdata, mem_word(32'h1000));
                4: check1("both_idle_gap", mem_req, 1'b0);
                5: check32("both_second_addr", mem_addr, 32'h40);
                7: check32("both_if_rdata", if_rdata, 32'h20080005);
                default: ;
            endcase
            if (dm_ack) dm_req = 1'b0;
        end
        if_req = 1'b0;
        tick();

        // Data requests back to back with a fetch waiting: fetch wins the third grant.
        apply_reset();
        resp_delay = 0;
        if_req   = 1'b1;
        if_addr  = 32'h80;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h1000;
        n_grants = 0;
        prev_req = 1'b0;
        for (int i = 0; i < 4; i++) grants[i] = '0;
        for (int c = 1; c <= 20 && n_grants < 4; c++) begin
            tick();
            if (mem_req && !prev_req) begin
                grants[n_grants] = mem_addr;
                n_grants++;
            end
            prev_req = mem_req;
            if (if_ack) if_req = 1'b0;
        end
        check32("starve_n_grants", n_grants, 4);
        check32("starve_g1", grants[0], 32'h1000);
        check32("starve_g2", grants[1], 32'h1000);
        check32("starve_g3", grants[2], 32'h80);
        check32("starve_g4", grants[3], 32'h1000);
        dm_req = 1'b0;
        if_req = 1'b0;
        tick();
        tick();
        tick();

        // Reset in the middle of a load abandons it without an ack.
        apply_reset();
        resp_delay = -1;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h1000;
        tick();
        tick();
        check1("midrst_busy", mem_req, 1'b1);
        reset  = 1'b0;
        dm_req = 1'b0;
        tick();
        check1("midrst_mem_req", mem_req, 1'b0);
        check32("midrst_mem_addr", mem_addr, 32'h0);
        check1("midrst_dm_ack", dm_ack, 1'b0);
        check32("midrst_dm_rdata", dm_rdata, 32'h0);
        check1("midrst_mem_err", mem_err, 1'b0);
        check1("midrst_stall", Stall, 1'b0);
        reset   = 1'b1;
        dm_acks = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            dm_acks += int'(dm_ack);
        end
        check32("midrst_no_ack", dm_acks, 0);
        reset = 1'b0;
        tick();
        reset      = 1'b1;
        resp_delay = 0;
        if_req     = 1'b1;
        if_addr    = 32'h40;
        tick();
        check1("post_rst_grant", mem_req, 1'b1);
        check32("post_rst_addr", mem_addr, 32'h40);
        tick();
        check1("post_rst_if_ack", if_ack, 1'b1);
        check32("post_rst_if_rdata", if_rdata, 32'h20080005);
        if_req = 1'b0;
        tick();

        run_random(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum cycles a memory access waits for mem_ready.
REQ-002 SHALL have parameter STARVE_LIMIT, default 2: the number of consecutive data grants after which a waiting fetch wins.
REQ-003 SHALL have clk  in  1: the single clock, rising edge.
REQ-004 SHALL have reset  in  1: synchronous, active-low (reset=0 resets).
REQ-005 SHALL have if_req in 1, if_addr in 32: the fetch-stage read request, held until if_ack.
REQ-006 SHALL have if_ack out 1, if_rdata out 32: a one-cycle fetch completion and its instruction word.
REQ-007 SHALL have dm_req in 1, dm_we in 1, dm_addr in 32, dm_wdata in 32: the MEM-stage request, held until dm_ack.
REQ-008 SHALL have dm_ack out 1, dm_rdata out 32: a one-cycle data completion and its load data.
REQ-009 SHALL have mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32: the single shared memory port.
REQ-010 SHALL have mem_rdata in 32, mem_ready in 1: the memory response, valid for the cycle in which mem_ready=1.
REQ-011 SHALL have Stall out 1: high while any requester is pending without an ack this cycle.
REQ-012 SHALL have mem_err out 1: sticky flag indicating a timeout occurred.

Function
REQ-013 SHALL use the states IDLE, IBUSY, DBUSY and RESP.
REQ-014 SHALL, in IDLE, grant dm_req over if_req except as stated in REQ-015; with no request pending, it SHALL stay in IDLE.
REQ-015 SHALL grant if_req when both requests are pending and the last STARVE_LIMIT grants were all data.
REQ-016 SHALL latch the address, we and wdata at grant; from the next cycle mem_req=1, held with the latched values stable until mem_ready.
REQ-017 SHALL, when mem_ready=1 in IBUSY/DBUSY, register mem_rdata into the owner's rdata, drop mem_req and enter RESP.
REQ-018 SHALL pulse the owner's ack for exactly the one cycle spent in RESP, grant nothing in RESP, then go to IDLE.
REQ-019 Latency: a request sampled in IDLE at cycle t with mem_ready at t+k SHALL produce its ack at t+k+1, and the next grant SHALL be at t+k+2.
REQ-020 SHALL, for a write, leave dm_rdata unchanged, with dm_ack following the same timing.
REQ-021 SHALL start a wait counter at 0 on grant and increment it each BUSY cycle without mem_ready.
REQ-022 SHALL, when the counter reaches MAX_WAIT, drop mem_req, set mem_err, load rdata=32'hDEADBEEF and enter RESP with an ack pulse.
REQ-023 SHALL give mem_ready precedence when it coincides with the timeout cycle: the access is normal and mem_err is not set.
REQ-024 SHALL ignore mem_ready in IDLE and RESP.
REQ-025 SHALL let the rdata registers hold their values between acks.
REQ-026 Stall = (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational.
REQ-027 SHALL never assert if_ack and dm_ack together.

Reset
REQ-028 SHALL, while reset=0 on a clock edge, load IDLE and clear mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata, mem_err, the wait counter and the starvation counter.
REQ-029 SHALL abandon any access in progress when reset is applied mid-access, with no ack issued; the first grant may occur on the first edge after reset=1.
REQ-030 SHALL clear mem_err only by reset.

Structure
REQ-031 SHALL place the state encoding, ERR_DATA=32'hDEADBEEF and the MAX_WAIT/STARVE_LIMIT defaults in the shared package.
REQ-032 SHALL implement the wait counter as sub-module arb_wait_timer (inputs: start, count enable; output: expired).
REQ-033 SHALL fit in 120-400 lines of RTL.

Verification
REQ-034 Fetch if_addr=0x0040, mem_ready 2 cycles after mem_req, mem_rdata=0x20080005 -> mem_addr=0x0040 is stable; if_ack is one cycle with if_rdata=0x20080005.
REQ-035 Simultaneous if_req and dm_req (lw from 0x1000) -> data is served first; fetch is served after RESP and IDLE; Stall stays high until if_ack.
REQ-036 dm_req held continuously and if_req pending -> after 2 data grants the fetch is granted on the 3rd.
REQ-037 Store dm_we=1, addr 0x1004, wdata 0xCAFEF00D -> mem_we=1 with those values; dm_ack is pulsed; dm_rdata is unchanged.
REQ-038 mem_ready never arrives -> after 15 wait cycles mem_req=0, ack with 0xDEADBEEF, mem_err=1 stays set until reset; with mem_ready on cycle 15 instead -> normal completion, mem_err=0.
REQ-039 reset=0 during DBUSY -> next cycle IDLE, mem_req=0, no dm_ack, all outputs zero.
